// File: rtl/crossbar_port_sched.sv
// crossbar_port_sched
//   Packet-level round-robin scheduler for one crossbar output port. Grants one
//   requesting input port, holds the grant until the last beat of the packet
//   is accepted, then rotates priority to the port after the winner.
//
//   Optional feature macro: CROSSBAR_SCHED_TIMEOUT_EN
//     Adds a stall watchdog that force-releases a grant after TIMEOUT_CYC
//     consecutive cycles without an accepted beat.
//
//   Ports
//     i_sys_clk, i_sys_rst_n : clock, asynchronous active-low reset
//     i_req                  : per-input request vector
//     i_beat_valid/ready/last: beat handshake of the granted (muxed) input
//     o_grant / o_grant_idx  : one-hot grant and its binary index (mux select)
//     o_grant_valid          : a grant is active
//     o_pkt_done             : 1-cycle pulse when a grant is released
//     o_timeout              : 1-cycle pulse when the release was a watchdog one
module crossbar_port_sched #(
  parameter int PORT_NUM    = 10,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                i_sys_clk,
  input  logic                i_sys_rst_n,
  input  logic [PORT_NUM-1:0] i_req,
  input  logic                i_beat_valid,
  input  logic                i_beat_ready,
  input  logic                i_beat_last,
  output logic [PORT_NUM-1:0] o_grant,
  output logic [IDX_W-1:0]    o_grant_idx,
  output logic                o_grant_valid,
  output logic                o_pkt_done,
  output logic                o_timeout
);

  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_e;

  state_e              state_q, state_d;
  logic [PORT_NUM-1:0] pri_q, pri_d;
  logic [PORT_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                gv_q, gv_d;
  logic                done_q, done_d;

  logic                  beat_acc;
  logic                  stall_hit;
  logic [2*PORT_NUM-1:0] req_dbl, win_dbl;
  logic [PORT_NUM-1:0]   win;
  logic [IDX_W-1:0]      win_idx;

  assign beat_acc = i_beat_valid & i_beat_ready;

  // First set request at or above the pointer, with wrap: subtracting the
  // one-hot pointer from the doubled vector clears exactly the lowest set
  // bit at/above it; the upper copy catches the wrapped case.
  assign req_dbl = {i_req, i_req};
  assign win_dbl = req_dbl & ~(req_dbl - {{PORT_NUM{1'b0}}, pri_q});
  assign win     = win_dbl[PORT_NUM-1:0] | win_dbl[2*PORT_NUM-1:PORT_NUM];

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < PORT_NUM; i++)
      if (win[i]) win_idx = IDX_W'(i);
  end

  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    gv_d    = gv_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          grant_d = win;
          idx_d   = win_idx;
          gv_d    = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if ((beat_acc && i_beat_last) || stall_hit) state_d = RELEASE;
      end
      RELEASE: begin
        grant_d = '0;
        idx_d   = '0;
        gv_d    = 1'b0;
        done_d  = 1'b1;
        // grant is one-hot, so rotating it left is one-hot(idx+1 mod N)
        pri_d   = {grant_q[PORT_NUM-2:0], grant_q[PORT_NUM-1]};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q <= IDLE;
      pri_q   <= PORT_NUM'(1);
      grant_q <= '0;
      idx_q   <= '0;
      gv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      gv_q    <= gv_d;
      done_q  <= done_d;
    end
  end

`ifdef CROSSBAR_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tpend_q;  // current RELEASE was caused by the watchdog
  logic             to_q;

  // cnt_q counts stalls already seen; this cycle is stall number cnt_q+1
  assign stall_hit = (state_q == XFER) && !beat_acc &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      cnt_q   <= '0;
      tpend_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      to_q <= (state_q == RELEASE) && tpend_q;
      if (state_q == XFER && stall_hit) tpend_q <= 1'b1;
      else if (state_q == RELEASE)      tpend_q <= 1'b0;
      if (state_q != XFER || beat_acc)  cnt_q   <= '0;
      else                              cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign o_timeout = to_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC > 0);
  assign stall_hit  = 1'b0;
  assign o_timeout  = 1'b0;
`endif

  assign o_grant       = grant_q;
  assign o_grant_idx   = idx_q;
  assign o_grant_valid = gv_q;
  assign o_pkt_done    = done_q;

endmodule

// File: tb/tb_crossbar_port_sched.sv
// Directed bench for crossbar_port_sched (PORT_NUM=10, TIMEOUT_CYC=8).
module tb_crossbar_port_sched;
  localparam int N = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          bv, br, bl;
  logic [N-1:0]  grant;
  logic [3:0]    gidx;
  logic          gv, done, tout;

  int n_assert = 0;
  int n_fail   = 0;

  crossbar_port_sched #(.PORT_NUM(N), .IDX_W(4), .TIMEOUT_CYC(8)) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_req        (req),
    .i_beat_valid (bv),
    .i_beat_ready (br),
    .i_beat_last  (bl),
    .o_grant      (grant),
    .o_grant_idx  (gidx),
    .o_grant_valid(gv),
    .o_pkt_done   (done),
    .o_timeout    (tout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // grant vector, index and valid in one go
  task automatic chk_g(input string tag, input int port, input logic valid);
    logic [N-1:0] eg;
    eg = valid ? (N'(1) << port) : '0;
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".idx"},   32'(gidx),  valid ? 32'(port) : 32'd0);
    chk({tag, ".gv"},    32'(gv),    32'(valid));
  endtask

  initial begin
    rst_n = 1'b0; req = '0; bv = 1'b0; br = 1'b0; bl = 1'b0;
    #12;
    chk_g("reset", 0, 1'b0);
    chk("reset.done", 32'(done), 0);
    chk("reset.tout", 32'(tout), 0);
    #1 rst_n = 1'b1;
    tick();
    chk_g("idle", 0, 1'b0);

    // 3-beat packet on port 2
    req = 10'h004;
    tick();
    chk_g("p2.grant", 2, 1'b1);
    req = '0; bv = 1'b1; br = 1'b1; bl = 1'b0;
    tick(); tick();
    chk_g("p2.mid", 2, 1'b1);
    bl = 1'b1;
    tick();                         // last beat accepted
    chk_g("p2.release", 2, 1'b1);
    chk("p2.release.done", 32'(done), 0);
    bv = 1'b0; bl = 1'b0;
    tick();
    chk_g("p2.done", 0, 1'b0);
    chk("p2.done.pulse", 32'(done), 1);
    tick();
    chk("p2.done.clear", 32'(done), 0);

    // all requesting, single-beat packets: pointer now at 3, wraps past 9
    req = 10'h3FF; bv = 1'b1; br = 1'b1; bl = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      chk_g($sformatf("rr%0d.grant", k), (3 + k) % N, 1'b1);
      tick();
      chk($sformatf("rr%0d.hold", k), 32'(gv), 1);
      tick();
      chk($sformatf("rr%0d.gap", k), 32'(gv), 0);
      chk($sformatf("rr%0d.done", k), 32'(done), 1);
    end

    // port 4 held while others request and port 4 drops its request
    bv = 1'b0; req = 10'h010;
    tick();
    chk_g("p4.grant", 4, 1'b1);
    req = 10'h3EF; bv = 1'b1; br = 1'b1; bl = 1'b0;
    tick(); tick();
    chk_g("p4.hold", 4, 1'b1);
    bl = 1'b1; br = 1'b0;
    tick();                         // last beat not accepted
    chk_g("p4.notready", 4, 1'b1);
    chk("p4.notready.done", 32'(done), 0);
    br = 1'b1;
    tick();
    chk_g("p4.release", 4, 1'b1);
    bv = 1'b0;
    tick();
    chk("p4.done", 32'(done), 1);
    tick();
    chk_g("p5.grant", 5, 1'b1);

    // finish port 5, then port 9 with stalled last beat, then wrap to 0
    bv = 1'b1; bl = 1'b1; br = 1'b1;
    tick();
    bv = 1'b0;
    tick();
    req = 10'h200;
    tick();
    chk_g("p9.grant", 9, 1'b1);
    req = 10'h201; bv = 1'b1; bl = 1'b1; br = 1'b0;
    tick(); tick(); tick();
    chk_g("p9.stall", 9, 1'b1);
    br = 1'b1;
    tick();
    chk_g("p9.release", 9, 1'b1);
    bv = 1'b0;
    tick();
    chk_g("p9.done", 0, 1'b0);
    chk("p9.done.pulse", 32'(done), 1);
    tick();
    chk_g("wrap.p0", 0, 1'b1);

    // finish port 0 (pointer -> 1), grant port 2, then reset mid-packet
    bv = 1'b1;
    tick();
    bv = 1'b0; req = 10'h004;
    tick();
    tick();
    chk_g("p2b.grant", 2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_g("rst.async", 0, 1'b0);
    chk("rst.async.done", 32'(done), 0);
    #2 rst_n = 1'b1; req = 10'h3FF;
    tick();
    chk_g("rst.p0", 0, 1'b1);

`ifdef CROSSBAR_SCHED_TIMEOUT_EN
    repeat (8) tick();
    chk("to.before", 32'(tout), 0);
    chk_g("to.hold", 0, 1'b1);
    tick();
    chk("to.pulse", 32'(tout), 1);
    chk("to.done", 32'(done), 1);
    tick();
    chk_g("to.next", 1, 1'b1);
`else
    repeat (120) tick();
    chk_g("long.hold", 0, 1'b1);
    chk("long.done", 32'(done), 0);
    chk("long.tout", 32'(tout), 0);
`endif

    // release, then beats while idle must do nothing
    req = '0; bv = 1'b1; br = 1'b1; bl = 1'b1;
    tick();
    chk("end.release", 32'(gv), 1);
    tick();
    chk("end.done", 32'(done), 1);
    chk("end.tout", 32'(tout), 0);
    tick();
    chk_g("end.idle", 0, 1'b0);
    chk("end.idle.done", 32'(done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
